mips_avalon_arbiter: RTL and testbench
======================================

// Module: mips_avalon_arbiter
// PURPOSE
//  Shares one Avalon-MM slave port (unified RAM) between the CPU instruction-fetch master (I, read-only)
//  and the data master (D, read/write). Sits between the MIPS core and memory.
//  Round-robin or data-first arbitration, one transaction per grant.
//  Adds stuck-slave timeout and protocol-error detection.
// PARAMETERS
//  DATA_PRIORITY  0   0 = round-robin on simultaneous requests; 1 = D always wins ties
//  TIMEOUT        64  max cycles m_waitrequest may stay high in a grant before timeout is set; 0 disables
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   synchronous, active-high
//  i_address      in   32  instr master word address
//  i_read         in   1   instr master read request
//  i_waitrequest  out  1   stall to instr master
//  i_readdata     out  32  read data to instr master
//  d_address      in   32  data master address
//  d_read         in   1   data master read
//  d_write        in   1   data master write
//  d_writedata    in   32  data master write data
//  d_byteenable   in   4   data master byte enables
//  d_waitrequest  out  1   stall to data master
//  d_readdata     out  32  read data to data master
//  m_address      out  32  to slave
//  m_read         out  1   to slave
//  m_write        out  1   to slave
//  m_writedata    out  32  to slave
//  m_byteenable   out  4   to slave (4'b1111 during I grant)
//  m_waitrequest  in   1   from slave
//  m_readdata     in   32  from slave
//  proto_err      out  1   sticky: master dropped request mid-grant, or d_read&&d_write
//  timeout        out  1   sticky: slave waitrequest exceeded TIMEOUT cycles
// BEHAVIOUR
//  States: IDLE, GNT_I, GNT_D. Registered state plus last_gnt bit (0=I, 1=D).
//  Reset: state=IDLE, last_gnt=D (I wins first tie), proto_err=0, timeout=0, wait counter=0.
//   Next-cycle outputs: m_read=m_write=0, i_/d_waitrequest=1.
//  IDLE: m_read=m_write=0; both waitrequests=1 (no combinational pass-through).
//   Only I requests -> GNT_I. Only D requests (read xor write) -> GNT_D.
//   Both request: DATA_PRIORITY=1 -> GNT_D; else grant the one != last_gnt.
//   d_read&&d_write in IDLE: D not eligible; set proto_err.
//  GNT_x: m_* driven combinationally from granted master (m_address/m_read/m_write/m_writedata/m_byteenable).
//   x_waitrequest = m_waitrequest; x_readdata = m_readdata.
//   Ungranted master: waitrequest=1.
//   Completion: granted read/write high && m_waitrequest=0 in same cycle.
//    Granted master sees waitrequest=0 that cycle; next state IDLE; last_gnt=x.
//   Granted master drops read/write before completion: next state IDLE, proto_err=1,
//    m_read/m_write follow master (low) that cycle.
//  Latency: min 1 arbitration cycle + slave latency. With 0-wait slave, a lone master completes
//   in cycle 2 of its request. Back-to-back grants always separated by one IDLE cycle.
//  Wait counter: cleared on entering GNT_x; increments each grant cycle m_waitrequest=1, saturating.
//   Reaching TIMEOUT sets timeout. Transaction is not aborted; grant is held.
//  i_readdata/d_readdata always = m_readdata; valid only when that master's waitrequest=0.
//  Master address/data must stay stable while its waitrequest=1; the arbiter does not latch them.
//  Reset mid-grant: abandons transaction; m_read/m_write low from next cycle; no completion reported.
// TESTING
//  1 Reset held 2 cycles, no requests -> m_read=m_write=0, i_/d_waitrequest=1, proto_err=timeout=0.
//  2 Lone I read 0xBFC00000, slave 2-wait returning 0x[national-id] -> i_waitrequest low exactly 1 cycle
//     with i_readdata=0x[national-id], 4 cycles after request (1 arb + 3 slave); m_byteenable=4'hF.
//  3 I read and D write (addr 0x10, data 0xDEADBEEF, be 4'b0011) same cycle, DATA_PRIORITY=0 after reset
//     -> I served first, one IDLE cycle, then D; slave sees write 0xDEADBEEF be 4'b0011 at 0x10.
//  4 Same as 3 with DATA_PRIORITY=1 -> D served first; continuous I+D requests with DATA_PRIORITY=0
//     -> grants strictly alternate I,D,I,D.
//  5 D asserts d_read&&d_write -> proto_err=1, no slave access; D drops d_read mid-grant -> IDLE, proto_err stays 1.
//  6 TIMEOUT=8, slave holds m_waitrequest 20 cycles -> timeout=1 after 8 grant cycles; completes at cycle 20,
//     grant then released; reset mid-grant -> m_read=0 next cycle.

Source files
------------

// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter
//   Shares one Avalon-MM slave port (unified RAM) between the MIPS core's
//   instruction-fetch master (I, read-only) and its data master (D, read/write).
//   The arbiter grants one transaction at a time. On a tie it uses round-robin
//   or lets D win, depending on DATA_PRIORITY. It also flags a stuck slave
//   (sticky timeout) and master protocol errors (sticky proto_err).
//
// Parameters
//   DATA_PRIORITY  0 = round-robin on simultaneous requests, 1 = D wins ties
//   TIMEOUT        number of waitrequest cycles in one grant before timeout sets; 0 disables
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   i_address/i_read               I master request
//   i_waitrequest/i_readdata       I master response
//   d_address/d_read/d_write       D master request
//   d_writedata/d_byteenable       D master write payload
//   d_waitrequest/d_readdata       D master response
//   m_*                            slave-side Avalon-MM port
//   proto_err                      sticky: request dropped mid-grant, or d_read && d_write
//   timeout                        sticky: slave stalled TIMEOUT cycles within one grant
module mips_avalon_arbiter #(
    parameter int DATA_PRIORITY = 0,
    parameter int TIMEOUT       = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        proto_err,
    output logic        timeout
);

    // The counter is wide enough to reach TIMEOUT, and it saturates at all-ones.
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t             state_q, state_d;
    logic               last_gnt_q, last_gnt_d;   // 0 = I, 1 = D
    logic               proto_err_q, proto_err_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic d_req;
    logic d_both;

    assign d_req      = d_read ^ d_write;
    assign d_both     = d_read & d_write;
    assign i_readdata = m_readdata;
    assign d_readdata = m_readdata;
    assign proto_err  = proto_err_q;
    assign timeout    = timeout_q;

    always_comb begin
        state_d       = state_q;
        last_gnt_d    = last_gnt_q;
        proto_err_d   = proto_err_q | d_both;
        timeout_d     = timeout_q;
        wait_cnt_d    = wait_cnt_q;
        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;

        case (state_q)
            IDLE: begin
                // Clearing here means every grant starts with a zero count.
                wait_cnt_d = '0;
                if (i_read && d_req) begin
                    // On a tie, D wins if it has priority or if I was served last.
                    if (DATA_PRIORITY != 0 || !last_gnt_q) state_d = GNT_D;
                    else                                   state_d = GNT_I;
                end else if (i_read) begin
                    state_d = GNT_I;
                end else if (d_req) begin
                    state_d = GNT_D;
                end
            end

            GNT_I: begin
                m_address     = i_address;
                m_read        = i_read;
                m_byteenable  = 4'hF;
                i_waitrequest = m_waitrequest;
                if (!i_read) begin
                    state_d     = IDLE;
                    proto_err_d = 1'b1;
                end else if (!m_waitrequest) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                end
            end

            GNT_D: begin
                m_address     = d_address;
                m_read        = d_read;
                m_write       = d_write;
                m_writedata   = d_writedata;
                m_byteenable  = d_byteenable;
                d_waitrequest = m_waitrequest;
                if (!(d_read || d_write)) begin
                    state_d     = IDLE;
                    proto_err_d = 1'b1;
                end else if (!m_waitrequest) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        // Count stalls only while a grant is in progress. The transaction is
        // never aborted; timeout only flags the stall.
        if (state_q != IDLE && m_waitrequest) begin
            if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + CNT_W'(1);
            if (TIMEOUT != 0 && int'(wait_cnt_q) + 1 >= TIMEOUT) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;      // I wins the first tie
            proto_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            proto_err_q <= proto_err_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
module tb_mips_avalon_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_address, d_address, d_writedata, m_readdata;
    logic        i_read, d_read, d_write, m_waitrequest;
    logic [3:0]  d_byteenable;

    // dut0: round-robin, dut1: data priority; both use TIMEOUT=8 and share stimulus.
    logic        i_wr0, d_wr0, m_rd0, m_wr0, pe0, to0;
    logic [31:0] i_rdat0, d_rdat0, m_addr0, m_wdat0;
    logic [3:0]  m_be0;
    logic        i_wr1, d_wr1, m_rd1, m_wr1, pe1, to1;
    logic [31:0] i_rdat1, d_rdat1, m_addr1, m_wdat1;
    logic [3:0]  m_be1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_avalon_arbiter #(.DATA_PRIORITY(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_wr0), .i_readdata(i_rdat0),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
        .d_byteenable(d_byteenable), .d_waitrequest(d_wr0), .d_readdata(d_rdat0),
        .m_address(m_addr0), .m_read(m_rd0), .m_write(m_wr0), .m_writedata(m_wdat0),
        .m_byteenable(m_be0), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .proto_err(pe0), .timeout(to0)
    );

    mips_avalon_arbiter #(.DATA_PRIORITY(1), .TIMEOUT(8)) dut1 (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_wr1), .i_readdata(i_rdat1),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
        .d_byteenable(d_byteenable), .d_waitrequest(d_wr1), .d_readdata(d_rdat1),
        .m_address(m_addr1), .m_read(m_rd1), .m_write(m_wr1), .m_writedata(m_wdat1),
        .m_byteenable(m_be1), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .proto_err(pe1), .timeout(to1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the posedge; checks happen at the negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; i_address = '0; i_read = 0; d_address = '0; d_read = 0; d_write = 0;
        d_writedata = '0; d_byteenable = '0; m_waitrequest = 0; m_readdata = '0;

        // 1: reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_m_read", m_rd0, 0);
        chk("rst_m_write", m_wr0, 0);
        chk("rst_i_wait", i_wr0, 1);
        chk("rst_d_wait", d_wr0, 1);
        chk("rst_proto", pe0, 0);
        chk("rst_timeout", to0, 0);
        tick(); reset = 1'b0;

        // 2: lone I read, slave inserts 2 wait states
        i_address = 32'hBFC0_0000; i_read = 1; m_waitrequest = 1; m_readdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("i_arb_m_read", m_rd0, 0);
        chk("i_arb_wait", i_wr0, 1);
        tick();
        @(negedge clk);
        chk("i_g1_m_read", m_rd0, 1);
        chk("i_g1_addr", m_addr0, 32'hBFC0_0000);
        chk("i_g1_be", m_be0, 4'hF);
        chk("i_g1_wait", i_wr0, 1);
        chk("i_g1_d_wait", d_wr0, 1);
        tick();
        @(negedge clk);
        chk("i_g2_wait", i_wr0, 1);
        tick(); m_waitrequest = 0;
        @(negedge clk);
        chk("i_done_wait", i_wr0, 0);
        chk("i_done_data", i_rdat0, 32'h0BAD_F00D);
        tick(); i_read = 0;
        @(negedge clk);
        chk("i_after_wait", i_wr0, 1);
        chk("i_after_m_read", m_rd0, 0);
        chk("i_after_timeout", to0, 0);
        chk("i_after_proto", pe0, 0);

        // 3/4: simultaneous I read and D write, held continuously
        do_reset();
        i_address = 32'h100; i_read = 1;
        d_address = 32'h10; d_write = 1; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
        @(negedge clk);
        chk("tie_arb_rd0", m_rd0, 0);
        chk("tie_arb_wr1", m_wr1, 0);
        tick();
        @(negedge clk);
        chk("rr_g1_read", m_rd0, 1);
        chk("rr_g1_write", m_wr0, 0);
        chk("rr_g1_addr", m_addr0, 32'h100);
        chk("rr_g1_i_wait", i_wr0, 0);
        chk("rr_g1_d_wait", d_wr0, 1);
        chk("dp_g1_write", m_wr1, 1);
        chk("dp_g1_addr", m_addr1, 32'h10);
        chk("dp_g1_data", m_wdat1, 32'hDEAD_BEEF);
        chk("dp_g1_be", m_be1, 4'b0011);
        chk("dp_g1_d_wait", d_wr1, 0);
        chk("dp_g1_i_wait", i_wr1, 1);
        tick();
        @(negedge clk);
        chk("rr_idle_read", m_rd0, 0);
        chk("rr_idle_write", m_wr0, 0);
        tick();
        @(negedge clk);
        chk("rr_g2_write", m_wr0, 1);
        chk("rr_g2_read", m_rd0, 0);
        chk("rr_g2_addr", m_addr0, 32'h10);
        chk("rr_g2_data", m_wdat0, 32'hDEAD_BEEF);
        chk("rr_g2_be", m_be0, 4'b0011);
        chk("rr_g2_d_wait", d_wr0, 0);
        chk("dp_g2_write", m_wr1, 1);
        tick();
        tick();
        @(negedge clk);
        chk("rr_g3_read", m_rd0, 1);
        chk("rr_g3_be", m_be0, 4'hF);
        chk("dp_g3_write", m_wr1, 1);
        tick(); i_read = 0; d_write = 0;
        @(negedge clk);
        chk("rr_end_proto", pe0, 0);
        chk("dp_end_proto", pe1, 0);

        // 5: illegal d_read && d_write in IDLE, then D drops request mid-grant
        do_reset();
        d_read = 1; d_write = 1;
        @(negedge clk);
        chk("both_m_read", m_rd0, 0);
        chk("both_m_write", m_wr0, 0);
        tick(); d_read = 0; d_write = 0;
        @(negedge clk);
        chk("both_proto", pe0, 1);
        chk("both_no_read", m_rd0, 0);
        chk("both_no_write", m_wr0, 0);
        do_reset();
        d_address = 32'h40; d_read = 1; m_waitrequest = 1;
        tick();
        @(negedge clk);
        chk("drop_g_read", m_rd0, 1);
        chk("drop_g_wait", d_wr0, 1);
        chk("drop_g_proto", pe0, 0);
        tick(); d_read = 0;
        @(negedge clk);
        chk("drop_follow", m_rd0, 0);
        tick();
        @(negedge clk);
        chk("drop_proto", pe0, 1);
        chk("drop_idle_wait", d_wr0, 1);
        tick();
        @(negedge clk);
        chk("drop_proto_sticky", pe0, 1);

        // 6: slave stalls 20 grant cycles with TIMEOUT=8, then reset mid-grant
        do_reset();
        i_address = 32'h200; i_read = 1; m_waitrequest = 1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            @(negedge clk);
            if (k == 1)  chk("to_g_read", m_rd0, 1);
            if (k == 8)  chk("to_cyc8", to0, 0);
            if (k == 9)  chk("to_cyc9", to0, 1);
            if (k == 20) chk("to_cyc20_wait", i_wr0, 1);
        end
        tick(); m_waitrequest = 0;
        @(negedge clk);
        chk("to_done_wait", i_wr0, 0);
        chk("to_done_read", m_rd0, 1);
        tick(); i_read = 0;
        @(negedge clk);
        chk("to_release_read", m_rd0, 0);
        chk("to_sticky", to0, 1);
        chk("to_no_proto", pe0, 0);
        i_read = 1; m_waitrequest = 1;
        tick();
        @(negedge clk);
        chk("rst_mid_pre", m_rd0, 1);
        tick(); reset = 1;
        tick();
        @(negedge clk);
        chk("rst_mid_read", m_rd0, 0);
        chk("rst_mid_wait", i_wr0, 1);
        chk("rst_mid_timeout", to0, 0);
        reset = 0; i_read = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
